bcd_countdown_timer: RTL

- Parametrised cascaded BCD countdown timer; successor to the single-digit mod-10 down counter.
- Counts NUM_FIELDS two-digit fields (default MM:SS) down on an external tick.
- Adds a run/pause/expire state machine, a per-field modulus, BCD input validation and a one-cycle expiry pulse.
- Sits between the 1 Hz tick divider and the 7-segment display driver.

---
 rtl/bcd_countdown_timer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Cascaded BCD countdown timer. NUM_FIELDS two-digit BCD fields, field 0
//   least significant, count down by one on each tick while running. It has
//   a run/pause/expire state machine, clamps load data to legal BCD, and
//   emits a one-cycle pulse when the count expires.
//
// Optional feature (macro BCD_TIMER_AUTO_RELOAD_EN):
//   When defined, expiry reloads the last preset value and stays in RUN.
//   If that preset is zero, the timer goes to EXPIRED as usual.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   synchronous active-high reset, highest priority
//   load     in   preset the count from data; forces IDLE
//   data     in   BCD preset, {tens,units} per field, field 0 in [7:0]
//   start    in   IDLE/PAUSED -> RUN when count is non-zero
//   pause    in   RUN -> PAUSED
//   tick     in   one-cycle count enable
//   out      out  current BCD count, same layout as data
//   zero     out  count is all zeros
//   tc       out  one-cycle pulse on the expiry decrement
//   running  out  state == RUN
//   state    out  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | count held, waiting for start
// RUN     | count decrements on tick
// PAUSED  | count held, start resumes
// EXPIRED | count reached zero, held until load or clear
module bcd_countdown_timer #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_MOD  = 60,
  parameter int TOP_MOD    = 100
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load,
  input  logic [8*NUM_FIELDS-1:0] data,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  output logic [8*NUM_FIELDS-1:0] out,
  output logic                    zero,
  output logic                    tc,
  output logic                    running,
  output logic [1:0]              state
);

  localparam int W = 8 * NUM_FIELDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t         state_q, state_nxt;
  logic [W-1:0]   cnt_q, cnt_nxt;
  logic           tc_nxt;
  logic           expire_hit;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0]   preset_q, preset_nxt;
`endif

  // Largest legal tens digit of a field.
  function automatic logic [3:0] tens_max(input int f);
    return 4'(((f == NUM_FIELDS - 1) ? TOP_MOD : FIELD_MOD) / 10 - 1);
  endfunction

  function automatic logic [W-1:0] clamp(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic [3:0]   u, t, tm;
    r = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      u  = d[8*f +: 4];
      t  = d[8*f+4 +: 4];
      tm = tens_max(f);
      r[8*f +: 4]   = (u > 4'd9) ? 4'd9 : u;
      r[8*f+4 +: 4] = (t > tm) ? tm : t;
    end
    return r;
  endfunction

  // Borrow ripples upward; never leaves the top field because the count
  // expires at 1 instead of decrementing to 0 and below.
  function automatic logic [W-1:0] dec(input logic [W-1:0] c);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   u, t;
    r      = c;
    borrow = 1'b1;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      u = c[8*f +: 4];
      t = c[8*f+4 +: 4];
      if (borrow) begin
        if (u != 4'd0) begin
          r[8*f +: 4] = u - 4'd1;
          borrow      = 1'b0;
        end else begin
          r[8*f +: 4] = 4'd9;
          if (t != 4'd0) begin
            r[8*f+4 +: 4] = t - 4'd1;
            borrow        = 1'b0;
          end else begin
            r[8*f+4 +: 4] = tens_max(f);
          end
        end
      end
    end
    return r;
  endfunction

  assign expire_hit = (cnt_q == {{(W-1){1'b0}}, 1'b1});

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zero    <= 1'b1;
      tc      <= 1'b0;
      running <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      preset_q <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      zero    <= (cnt_nxt == '0);
      tc      <= tc_nxt;
      running <= (state_nxt == RUN);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      preset_q <= preset_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSED: if (start && !zero) state_nxt = RUN;
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick && expire_hit) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (preset_q == '0) state_nxt = EXPIRED;
`else
            state_nxt = EXPIRED;
`endif
          end
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  // Count / pulse logic
  always_comb begin
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    preset_nxt = preset_q;
`endif
    if (load) begin
      cnt_nxt = clamp(data);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      preset_nxt = clamp(data);
`endif
    end else if (state_q == RUN && !pause && tick) begin
      if (expire_hit) begin
        tc_nxt = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        cnt_nxt = preset_q;
`else
        cnt_nxt = '0;
`endif
      end else begin
        cnt_nxt = dec(cnt_q);
      end
    end
  end

  assign out   = cnt_q;
  assign state = state_q;

endmodule
